// File: rtl/present_encrypt_ctrl.sv
// Sequencing controller for an iterative PRESENT-80 core: accepts one plaintext/key
// pair, starts the core, captures its ciphertext after ROUNDS edges, and holds it for the consumer.
module present_encrypt_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_ptext,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_ctext,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  output logic        core_load,
  input  logic [63:0] core_odat,
  input  logic        core_done,
  output logic        busy,
  output logic        err,
  output logic [15:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [4:0] ROUNDS_C = 5'(ROUNDS);

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic        capture_s;
  logic        release_s;
  logic [4:0]  rnd_r;
  logic [63:0] pt_r;
  logic [79:0] key_r;
  logic [63:0] ctext_r;
  logic        ovalid_r;
  logic        err_r;
  logic [15:0] blk_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        load_r;

  // Handshake qualifiers and next-state decode.
  always_comb begin
    state_s   = state_r;
    accept_s  = (state_r == IDLE) && in_valid;
    capture_s = (state_r == RUN) && (rnd_r == ROUNDS_C);
    release_s = (state_r == HOLD) && out_ready;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: state_s = RUN;
      RUN: begin
        if (capture_s) state_s = HOLD;
        else           state_s = RUN;
      end
      HOLD: begin
        if (release_s) state_s = IDLE;
        else           state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus status flags decoded from the next state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      load_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
      load_r     <= (state_s == LOAD);
    end
  end

  // Pair registers feed the core and only change when a new pair is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_r  <= 64'd0;
      key_r <= 80'd0;
    end else if (accept_s) begin
      pt_r  <= in_ptext;
      key_r <= in_key;
    end else begin
      pt_r  <= pt_r;
      key_r <= key_r;
    end
  end

  // Round counter starts at 1 on the load edge; at ROUNDS=31 it wraps to 0 with the core's own counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_r <= 5'd0;
    end else if (state_r == LOAD) begin
      rnd_r <= 5'd1;
    end else if (state_r == RUN) begin
      rnd_r <= rnd_r + 5'd1;
    end else begin
      rnd_r <= rnd_r;
    end
  end

  // Result capture, output handshake, block counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctext_r  <= 64'd0;
      ovalid_r <= 1'b0;
      blk_r    <= 16'd0;
      err_r    <= 1'b0;
    end else if (capture_s) begin
      ctext_r  <= core_odat;
      ovalid_r <= 1'b1;
      blk_r    <= blk_r + 16'd1;
      err_r    <= err_r | ~core_done;
    end else if (release_s) begin
      ctext_r  <= ctext_r;
      ovalid_r <= 1'b0;
      blk_r    <= blk_r;
      err_r    <= err_r;
    end else begin
      ctext_r  <= ctext_r;
      ovalid_r <= ovalid_r;
      blk_r    <= blk_r;
      err_r    <= err_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign core_load = load_r;
  assign core_idat = pt_r;
  assign core_key  = key_r;
  assign out_valid = ovalid_r;
  assign out_ctext = ctext_r;
  assign err       = err_r;
  assign blk_cnt   = blk_r;

endmodule

// File: tb/tb_present_encrypt_ctrl.sv
// Bench for present_encrypt_ctrl: a stub PRESENT-80 core plus a transaction-level
// model (edges elapsed since acceptance) compared against the DUT on every falling edge.
module tb_present_encrypt_ctrl;

  localparam int ROUNDS = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_ptext;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ctext;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic        core_load;
  logic [63:0] core_odat;
  logic        core_done;
  logic        busy;
  logic        err;
  logic [15:0] blk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  present_encrypt_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ptext(in_ptext), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctext(out_ctext),
    .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
    .core_odat(core_odat), .core_done(core_done),
    .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      p = 64'd0;
      for (int b = 0; b < 63; b++) p[(16*b) % 63] = s[b];
      p[63] = s[63];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub core: down-counter reaches zero in the cycle the controller must capture.
  logic        force_bad = 1'b0;
  logic        s_act;
  logic [4:0]  s_cnt;
  logic [63:0] s_pt;
  logic [63:0] s_ct;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_act <= 1'b0; s_cnt <= 5'd0; s_pt <= 64'd0; s_ct <= 64'd0;
    end else if (core_load) begin
      s_act <= 1'b1; s_cnt <= 5'(ROUNDS - 1); s_pt <= core_idat;
      s_ct  <= present80(core_idat, core_key);
    end else if (s_act && s_cnt != 5'd0) begin
      s_cnt <= s_cnt - 5'd1;
    end else begin
      s_act <= 1'b0;
    end
  end
  assign core_done = s_act && (s_cnt == 5'd0) && !force_bad;
  assign core_odat = (s_act && s_cnt == 5'd0) ? s_ct : (s_pt ^ {59'd0, s_cnt});

  // Reference model: one job at a time, timed by edges since its acceptance.
  logic        m_busy, m_hold, m_ov, m_err;
  int          m_age;
  logic [63:0] m_pt, m_ct;
  logic [79:0] m_key;
  logic [15:0] m_blk;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_ov <= 1'b0; m_err <= 1'b0; m_age <= 0;
      m_pt <= 64'd0; m_key <= 80'd0; m_ct <= 64'd0; m_blk <= 16'd0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1; m_age <= 0; m_pt <= in_ptext; m_key <= in_key;
      end
    end else begin
      m_age <= m_age + 1;
      if (!m_hold && m_age == ROUNDS) begin
        m_hold <= 1'b1; m_ov <= 1'b1; m_ct <= present80(m_pt, m_key);
        m_blk <= m_blk + 16'd1;
        if (force_bad) m_err <= 1'b1;
      end else if (m_hold && out_ready) begin
        m_hold <= 1'b0; m_ov <= 1'b0; m_busy <= 1'b0;
      end
    end
  end

  // Per-cycle compare, plus load-pulse width, latency and back-to-back spacing.
  int   cyc = 0;
  int   load_cyc = -1;
  int   loads = 0;
  logic b2b = 1'b0;
  logic cl_prev = 1'b0;
  logic ov_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    chk("in_ready", 80'(in_ready), 80'(!m_busy));
    chk("busy", 80'(busy), 80'(m_busy));
    chk("core_load", 80'(core_load), 80'(m_busy && m_age == 0));
    chk("out_valid", 80'(out_valid), 80'(m_ov));
    chk("out_ctext", 80'(out_ctext), 80'(m_ct));
    chk("err", 80'(err), 80'(m_err));
    chk("blk_cnt", 80'(blk_cnt), 80'(m_blk));
    chk("core_idat", 80'(core_idat), 80'(m_pt));
    chk("core_key", core_key, m_key);
    if (core_load === 1'b1) begin
      chk("core_load_single", 80'(cl_prev), 80'(0));
      if (b2b && load_cyc >= 0) chk("accept_spacing", 80'(cyc - load_cyc), 80'(ROUNDS + 3));
      load_cyc = cyc;
      loads++;
    end
    // Latency counts the accepting edge itself, so ROUNDS+2 edges inclusive.
    if (out_valid === 1'b1 && ov_prev === 1'b0 && load_cyc >= 0)
      chk("latency", 80'(cyc - load_cyc + 1), 80'(ROUNDS + 2));
    cl_prev = core_load;
    ov_prev = out_valid;
  end

  task automatic wait_ov(input string nm);
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) @(negedge clk);
    chk({nm, "_ov_timeout"}, 80'(out_valid), 80'(1));
  endtask

  task automatic run_vec(input logic [63:0] pt, input logic [79:0] key,
                         input logic [63:0] exp, input string nm);
    @(negedge clk); #1;
    in_valid = 1'b1; in_ptext = pt; in_key = key; out_ready = 1'b0;
    @(negedge clk); #1;
    in_valid = 1'b0;
    wait_ov(nm);
    chk(nm, 80'(out_ctext), 80'(exp));
    #1 out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [63:0] saved_ct;
  logic [15:0] saved_blk;
  logic [63:0] rpt;
  logic [79:0] rkey;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ptext = 64'd0; in_key = 80'd0; out_ready = 1'b0;
    chk("model_zero", 80'(present80(64'd0, 80'd0)), 80'(64'h5579c1387b228445));
    chk("model_keyones", 80'(present80(64'd0, {80{1'b1}})), 80'(64'he72c46c0f5945049));
    chk("model_ptones", 80'(present80({64{1'b1}}, 80'd0)), 80'(64'ha112ffc72f68417b));
    chk("model_allones", 80'(present80({64{1'b1}}, {80{1'b1}})), 80'(64'h3333dcd3213210d2));
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 80'(in_ready), 80'(1));
    chk("reset_blk_cnt", 80'(blk_cnt), 80'(0));
    #1 rst = 1'b0;

    run_vec(64'd0, 80'd0, 64'h5579c1387b228445, "vec_zero");
    chk("vec_zero_err", 80'(err), 80'(0));
    run_vec(64'd0, {80{1'b1}}, 64'he72c46c0f5945049, "vec_keyones");
    run_vec({64{1'b1}}, 80'd0, 64'ha112ffc72f68417b, "vec_ptones");
    run_vec({64{1'b1}}, {80{1'b1}}, 64'h3333dcd3213210d2, "vec_allones");
    chk("blk_after_four", 80'(blk_cnt), 80'(4));

    // Consumer stalls for 10 cycles while upstream keeps offering pairs.
    saved_blk = blk_cnt;
    @(negedge clk); #1;
    in_valid = 1'b1; in_ptext = 64'h0123456789abcdef; in_key = 80'h00112233445566778899;
    @(negedge clk); #1;
    in_valid = 1'b0;
    wait_ov("hold");
    saved_ct = out_ctext;
    chk("hold_ct", 80'(saved_ct), 80'(present80(64'h0123456789abcdef, 80'h00112233445566778899)));
    for (int i = 0; i < 10; i++) begin
      #1 in_valid = i[0]; in_ptext = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_stable", 80'(out_ctext), 80'(saved_ct));
      chk("hold_in_ready", 80'(in_ready), 80'(0));
      chk("hold_out_valid", 80'(out_valid), 80'(1));
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1 out_ready = 1'b0;
    chk("release_idle", 80'(in_ready), 80'(1));
    chk("release_blk", 80'(blk_cnt), 80'(saved_blk + 16'd1));

    // Reset pulsed with the round counter at 15.
    in_valid = 1'b1; in_ptext = 64'hdeadbeefcafef00d; in_key = 80'h0badc0de0badc0de0bad;
    @(negedge clk);
    chk("rst_test_load", 80'(core_load), 80'(1));
    #1 in_valid = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_core_load", 80'(core_load), 80'(0));
    chk("rst_blk", 80'(blk_cnt), 80'(0));
    chk("rst_ctext", 80'(out_ctext), 80'(0));
    chk("rst_idat", 80'(core_idat), 80'(0));
    chk("rst_key", core_key, 80'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 80'(in_ready), 80'(1));
    run_vec(64'd0, 80'd0, 64'h5579c1387b228445, "post_rst_vec");
    chk("post_rst_blk", 80'(blk_cnt), 80'(1));

    // Core reports not-done at capture: err sticks across good blocks until reset.
    force_bad = 1'b1;
    run_vec({64{1'b1}}, 80'd0, 64'ha112ffc72f68417b, "bad_vec");
    chk("err_set", 80'(err), 80'(1));
    force_bad = 1'b0;
    run_vec(64'd0, {80{1'b1}}, 64'he72c46c0f5945049, "good_after_bad1");
    run_vec(64'd0, 80'd0, 64'h5579c1387b228445, "good_after_bad2");
    chk("err_sticky", 80'(err), 80'(1));
    #1 rst = 1'b1;
    #1 chk("err_cleared", 80'(err), 80'(0));
    @(negedge clk); #1 rst = 1'b0;

    // Back-to-back with in_valid and out_ready held high.
    b2b = 1'b1; load_cyc = -1; loads = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4 * (ROUNDS + 3); i++) begin
      in_ptext = {$urandom, $urandom}; in_key = {$urandom, $urandom, 16'($urandom)};
      @(negedge clk); #1;
    end
    chk("b2b_loads", 80'(loads), 80'(4));
    in_valid = 1'b0; b2b = 1'b0;
    for (int i = 0; i < 60 && busy === 1'b1; i++) @(negedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      rpt = {$urandom, $urandom};
      rkey = {$urandom, $urandom, 16'($urandom)};
      in_ptext = rpt; in_key = rkey;
      out_ready = $urandom_range(0, 1) == 1;
      @(negedge clk); #1;
    end
    chk("random_made_progress", 80'(blk_cnt > 16'd10), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/present_encrypt_ctrl.md
PRESENT_ENCRYPT_CTRL -- requirements
Module: present_encrypt_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 31: clock edges from the core-load edge until the core signals ciphertext ready; legal range 1..31.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream offers a plaintext/key pair.
REQ-005 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-006 SHALL have port in_ptext, input, 64: plaintext.
REQ-007 SHALL have port in_key, input, 80: 80-bit cipher key.
REQ-008 SHALL have port out_valid, output, 1: out_ctext holds a finished ciphertext.
REQ-009 SHALL have port out_ready, input, 1: downstream consumes ciphertext.
REQ-010 SHALL have port out_ctext, output, 64: registered ciphertext.
REQ-011 SHALL have port core_idat, output, 64: plaintext to the core data input.
REQ-012 SHALL have port core_key, output, 80: key to the core key input.
REQ-013 SHALL have port core_load, output, 1: core load command.
REQ-014 SHALL have port core_odat, input, 64: core data output.
REQ-015 SHALL have port core_done, input, 1: core round-counter-zero flag.
REQ-016 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-017 SHALL have port err, output, 1: sticky flag, core_done low at capture.
REQ-018 SHALL have port blk_cnt, output, 16: count of completed blocks.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN, HOLD.
REQ-020 SHALL drive in_ready=1 only in IDLE.
REQ-021 SHALL, when in_valid and in_ready are both high at an edge, register in_ptext and in_key and go to LOAD.
REQ-022 SHALL drive core_idat and core_key from the registered pair at all times, changing only on acceptance.
REQ-023 SHALL drive core_load=1 for exactly the one cycle spent in LOAD, and 0 otherwise; it SHALL be a registered decode with no glitch.
REQ-024 SHALL, at the edge leaving LOAD, load a 5-bit round counter with 1 and enter RUN.
REQ-025 SHALL, in RUN, increment the counter each edge; the capture cycle is the cycle where the counter equals ROUNDS.
REQ-026 SHALL, for ROUNDS=31, make the capture cycle the cycle where the core round counter wraps to 0.
REQ-027 SHALL, at the edge ending the capture cycle: register core_odat into out_ctext, set out_valid, increment blk_cnt (wraps 0xFFFF->0), set err if core_done=0, and enter HOLD.
REQ-028 SHALL make total latency from the accepting edge to out_valid high equal ROUNDS+2 edges (33 at default).
REQ-029 SHALL hold out_valid and out_ctext stable in HOLD until out_ready=1 at an edge, then clear out_valid and return to IDLE.
REQ-030 SHALL make acceptance of a new pair possible no earlier than the cycle after the output handshake, so no pipelining is allowed.
REQ-031 SHALL ignore in_valid outside IDLE, with no change of state or registers.
REQ-032 SHALL leave err set until reset and never clear it by a handshake.
REQ-033 SHALL treat out_ready while out_valid=0 as a no-op.

Reset
REQ-034 SHALL, on rst high, immediately and asynchronously enter IDLE and clear out_valid, core_load, busy, err, blk_cnt, the round counter, out_ctext and the pair registers to 0.
REQ-035 SHALL, on reset mid-RUN or mid-HOLD, drop the pending block without raising out_valid; the first accept after reset restarts cleanly.
REQ-036 SHALL make in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-037 SHALL be checked with pt=0, key=0 -> out_ctext=5579c1387b228445, out_valid rises 33 edges after accept, err=0.
REQ-038 SHALL be checked with pt=0, key=FFFFFFFFFFFFFFFFFFFF -> e72c46c0f5945049; pt=FFFFFFFFFFFFFFFF, key=0 -> a112ffc72f68417b; both all-ones -> 3333dcd3213210d2.
REQ-039 SHALL be checked with out_ready held low 10 cycles after out_valid -> ctext stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge, blk_cnt+1.
REQ-040 SHALL be checked with rst pulsed at counter=15 -> all outputs 0 at once, no out_valid; next vector completes correctly.
REQ-041 SHALL be checked with a stub core forcing core_done=0 at capture -> err=1 and staying 1 across later good blocks until rst.
REQ-042 SHALL be checked with back-to-back vectors and in_valid held high -> exactly one core_load per block, accepts spaced ROUNDS+3 edges apart.
